// File: rtl/vrased_reset_ctl.sv
// rtl/vrased_reset_ctl.sv - VRASED violation reset controller with hold window and PC-gated release
// Optional cause/count logging enabled by defining VRASED_CAUSE_LOG_EN.
module vrased_reset_ctl #(
   parameter int          NUM_SRC       = 6,
   parameter int          HOLD_CYCLES   = 4,
   parameter int          CNT_W         = 8,
   parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [15:0]        pc,
   input  logic [NUM_SRC-1:0] viol,
   output logic               reset,
   output logic               busy,
   output logic [NUM_SRC-1:0] cause,
   output logic [CNT_W-1:0]   viol_cnt
);

   localparam int            HW        = $clog2(HOLD_CYCLES + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t        state;
   logic [HW-1:0] hold_cnt;
   logic          trig;

   // The combinational trigger term kills the core in the same cycle the violation appears.
   assign trig  = (state == IDLE) && (|viol);
   assign reset = trig | busy;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|viol) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_LOAD;
                  busy     <= 1'b1;
               end
            end
            HOLD: begin
               if (hold_cnt == '0) begin
                  state <= WAIT;
               end else begin
                  hold_cnt <= hold_cnt - HW'(1);
               end
            end
            WAIT: begin
               if (pc == RESET_HANDLER) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef VRASED_CAUSE_LOG_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cause    <= '0;
         viol_cnt <= '0;
      end else if (trig) begin
         cause <= viol;
         if (viol_cnt != {CNT_W{1'b1}}) begin
            viol_cnt <= viol_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign cause    = '0;
   assign viol_cnt = '0;
`endif

endmodule

// File: tb/tb_vrased_reset_ctl.sv
// tb/tb_vrased_reset_ctl.sv - scoreboard bench for vrased_reset_ctl against a trigger/release-time model
module tb_vrased_reset_ctl;

   localparam int          NSRC = 6;
   localparam int          HOLD = 4;
   localparam int          CW   = 2;
   localparam logic [15:0] RH   = 16'h0000;
   localparam int          CMAX = (1 << CW) - 1;
`ifdef VRASED_CAUSE_LOG_EN
   localparam bit LOG_EN = 1'b1;
`else
   localparam bit LOG_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [15:0]     pc = 16'hA000;
   logic [NSRC-1:0] viol = '0;
   logic            reset;
   logic            busy;
   logic [NSRC-1:0] cause;
   logic [CW-1:0]   viol_cnt;

   vrased_reset_ctl #(
      .NUM_SRC(NSRC), .HOLD_CYCLES(HOLD), .CNT_W(CW), .RESET_HANDLER(RH)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pc(pc), .viol(viol),
      .reset(reset), .busy(busy), .cause(cause), .viol_cnt(viol_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            rst;
      logic            bsy;
      logic [NSRC-1:0] cse;
      logic [CW-1:0]   cnt;
      int              cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   passed = 0;

   // Reference model: a trigger starts a reset window that may only close when pc hits
   // the handler at or after cycle trigger+HOLD+1.
   bit              act = 1'b0;
   int              trig_cyc = 0;
   int              cyc = 0;
   logic [NSRC-1:0] m_cause = '0;
   int              m_cnt = 0;

   task automatic chk(input string name, input int c, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got === want) passed++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, got, want);
   endtask

   task automatic drive_cycle(input logic [NSRC-1:0] v, input logic [15:0] p);
      exp_t e;
      @(posedge clk);
      #1;
      viol = v;
      pc   = p;
      e.rst = act || (v != '0);
      e.bsy = act;
      e.cse = LOG_EN ? m_cause : '0;
      e.cnt = LOG_EN ? CW'(m_cnt) : '0;
      e.cyc = cyc;
      q.push_back(e);
      if (!act && v != '0) begin
         act      = 1'b1;
         trig_cyc = cyc;
         m_cause  = v;
         if (m_cnt < CMAX) m_cnt++;
      end else if (act && cyc >= trig_cyc + HOLD + 1 && p == RH) begin
         act = 1'b0;
      end
      cyc++;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("reset", e.cyc, 32'(reset), 32'(e.rst));
         chk("busy", e.cyc, 32'(busy), 32'(e.bsy));
         chk("cause", e.cyc, 32'(cause), 32'(e.cse));
         chk("viol_cnt", e.cyc, 32'(viol_cnt), 32'(e.cnt));
      end
   end

   task automatic async_reset_pulse();
      @(negedge clk);
      #1;
      viol    = '0;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", cyc, 32'(busy), 32'd0);
      chk("arst_reset", cyc, 32'(reset), 32'd0);
      chk("arst_cause", cyc, 32'(cause), 32'd0);
      chk("arst_cnt", cyc, 32'(viol_cnt), 32'd0);
      viol = 6'b010000;
      #1;
      chk("arst_reset_viol", cyc, 32'(reset), 32'd1);
      viol    = '0;
      reset_n = 1'b1;
      act     = 1'b0;
      m_cause = '0;
      m_cnt   = 0;
   endtask

   initial begin
      #12;
      chk("por_reset", 0, 32'(reset), 32'd0);
      chk("por_busy", 0, 32'(busy), 32'd0);
      chk("por_cause", 0, 32'(cause), 32'd0);
      chk("por_cnt", 0, 32'(viol_cnt), 32'd0);
      @(negedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) drive_cycle('0, 16'hA000);

      // Single-cycle violation, pc reaches handler late.
      drive_cycle(6'b000100, 16'hA000);
      repeat (6) drive_cycle('0, 16'hA000);
      drive_cycle('0, 16'h0000);
      repeat (2) drive_cycle('0, 16'hA000);

      // Second violation during HOLD and handler pc during HOLD are both ignored.
      drive_cycle(6'b100001, 16'h0000);
      drive_cycle('0, 16'h0000);
      drive_cycle(6'b000010, 16'h0000);
      repeat (3) drive_cycle('0, 16'h0000);
      drive_cycle('0, 16'hA000);

      // Asynchronous reset in the middle of HOLD.
      drive_cycle(6'b001000, 16'hA000);
      repeat (2) drive_cycle('0, 16'hA000);
      async_reset_pulse();
      repeat (2) drive_cycle('0, 16'hA000);

      // Back-to-back triggers saturate the counter.
      for (int i = 0; i < 5; i++) begin
         drive_cycle(NSRC'($urandom_range(1, (1 << NSRC) - 1)), 16'h0000);
         repeat (5) drive_cycle('0, 16'h0000);
      end
      drive_cycle('0, 16'hA000);

      for (int i = 0; i < 400; i++) begin
         logic [NSRC-1:0] v;
         logic [15:0]     p;
         v = ($urandom_range(0, 5) == 0) ? NSRC'($urandom_range(1, (1 << NSRC) - 1)) : '0;
         p = ($urandom_range(0, 2) == 0) ? RH : 16'($urandom_range(1, 16'hFFFF));
         drive_cycle(v, p);
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("queue_drained", cyc, 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
